// File: rtl/param_readback_if.sv
// Byte stream between the parameter readback source and its sink: one byte per
// accepted valid/ready handshake, with frame position and end-of-frame marker.
interface param_readback_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic [4:0] byte_idx;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        output byte_idx,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        input  byte_idx,
        output dout_ready
    );
endinterface

// File: rtl/param_readback.sv
// Parameter bank readback: snapshots the 24-byte bank on start and streams it
// byte 0 first, optionally followed by an 8-bit additive checksum byte.
module param_readback #(
    parameter bit CSUM_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [191:0]     params,
    input  logic             start,
    param_readback_if.master stream,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam logic [4:0] LAST_PARAM_IDX = 5'd23;
    localparam logic [4:0] CSUM_IDX       = 5'd24;

    function automatic logic [7:0] byte_sel(input logic [191:0] bank, input logic [4:0] k);
        logic [191:0] shifted;
        shifted = bank >> {k, 3'b000};
        return shifted[7:0];
    endfunction

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    state_t       state_r;
    state_t       state_nxt_s;
    logic [191:0] snap_r;
    logic [191:0] snap_nxt_s;
    logic [7:0]   acc_r;
    logic [7:0]   acc_nxt_s;
    logic [7:0]   sum_s;
    logic [4:0]   idx_r;
    logic [4:0]   idx_nxt_s;
    logic [4:0]   idx_inc_s;
    logic [7:0]   dout_r;
    logic [7:0]   dout_nxt_s;
    logic         valid_r;
    logic         valid_nxt_s;
    logic         last_r;
    logic         last_nxt_s;
    logic         done_r;
    logic         done_nxt_s;
    logic         busy_r;
    logic         busy_nxt_s;
    logic         xfer_s;

    assign xfer_s    = valid_r & stream.dout_ready;
    assign sum_s     = csum_add(acc_r, dout_r);
    assign idx_inc_s = idx_r + 5'd1;

    assign stream.dout       = dout_r;
    assign stream.dout_valid = valid_r;
    assign stream.dout_last  = last_r;
    assign stream.byte_idx   = idx_r;
    assign busy              = busy_r;
    assign done              = done_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start only matters in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && (idx_r == LAST_PARAM_IDX)) begin
                    if (CSUM_EN) begin
                        state_nxt_s = CSUM;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CSUM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the output and datapath registers; holding is the default
    // so an un-accepted byte stays put while the sink stalls.
    always_comb begin
        snap_nxt_s  = snap_r;
        acc_nxt_s   = acc_r;
        idx_nxt_s   = idx_r;
        dout_nxt_s  = dout_r;
        valid_nxt_s = valid_r;
        last_nxt_s  = last_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // Byte 0 is taken straight from params since the snapshot
                    // is being loaded on this same edge.
                    snap_nxt_s  = params;
                    acc_nxt_s   = 8'd0;
                    idx_nxt_s   = 5'd0;
                    dout_nxt_s  = params[7:0];
                    valid_nxt_s = 1'b1;
                    last_nxt_s  = 1'b0;
                end else begin
                    idx_nxt_s   = 5'd0;
                    dout_nxt_s  = 8'd0;
                    valid_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                end
            end
            SEND: begin
                if (xfer_s) begin
                    acc_nxt_s = sum_s;
                    if (idx_r == LAST_PARAM_IDX) begin
                        if (CSUM_EN) begin
                            idx_nxt_s   = CSUM_IDX;
                            dout_nxt_s  = sum_s;
                            valid_nxt_s = 1'b1;
                            last_nxt_s  = 1'b1;
                        end else begin
                            idx_nxt_s   = 5'd0;
                            dout_nxt_s  = 8'd0;
                            valid_nxt_s = 1'b0;
                            last_nxt_s  = 1'b0;
                            done_nxt_s  = 1'b1;
                        end
                    end else begin
                        idx_nxt_s   = idx_inc_s;
                        dout_nxt_s  = byte_sel(snap_r, idx_inc_s);
                        valid_nxt_s = 1'b1;
                        last_nxt_s  = !CSUM_EN && (idx_inc_s == LAST_PARAM_IDX);
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    idx_nxt_s   = 5'd0;
                    dout_nxt_s  = 8'd0;
                    valid_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                idx_nxt_s   = 5'd0;
                dout_nxt_s  = 8'd0;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output and datapath registers; reset clears everything, aborting any frame
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r  <= 192'd0;
            acc_r   <= 8'd0;
            idx_r   <= 5'd0;
            dout_r  <= 8'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            snap_r  <= snap_nxt_s;
            acc_r   <= acc_nxt_s;
            idx_r   <= idx_nxt_s;
            dout_r  <= dout_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end
endmodule

// File: tb/tb_param_readback.sv
// Scoreboard bench for param_readback: one instance with the checksum byte and
// one without, driven and observed on the falling clock edge.
module tb_param_readback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [191:0] params1, params0;
    logic         start1, start0;
    logic         busy1, done1, busy0, done0;

    param_readback_if if1();
    param_readback_if if0();

    param_readback #(.CSUM_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .params(params1), .start(start1),
        .stream(if1.master), .busy(busy1), .done(done1)
    );
    param_readback #(.CSUM_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .params(params0), .start(start0),
        .stream(if0.master), .busy(busy0), .done(done0)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [13:0] sb_q[$];   // {byte_idx, last, byte}

    function automatic void push_frame(input logic [191:0] bank, input bit csum);
        logic [7:0] acc;
        logic [7:0] b;
        logic [4:0] kk;
        acc = 8'd0;
        for (int k = 0; k < 24; k++) begin
            b   = bank[8*k +: 8];
            kk  = 5'(k);
            acc = acc + b;
            sb_q.push_back({kk, (!csum && k == 23), b});
        end
        if (csum) sb_q.push_back({5'd24, 1'b1, acc});
    endfunction

    function automatic logic [191:0] ramp_bank();
        logic [191:0] bank;
        for (int k = 0; k < 24; k++) bank[8*k +: 8] = 8'(k + 1);
        return bank;
    endfunction

    // Advance to the next falling edge, present ready for the coming rising edge
    task automatic step1(input logic rdy, output bit xfer, output logic [13:0] obs);
        @(negedge clk);
        if1.dout_ready = rdy;
        xfer = if1.dout_valid && rdy;
        obs  = {if1.byte_idx, if1.dout_last, if1.dout};
    endtask

    task automatic step0(input logic rdy, output bit xfer, output logic [13:0] obs);
        @(negedge clk);
        if0.dout_ready = rdy;
        xfer = if0.dout_valid && rdy;
        obs  = {if0.byte_idx, if0.dout_last, if0.dout};
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b1; start0 = 1'b1;
        params1 = ramp_bank(); params0 = ramp_bank();
        if1.dout_ready = 1'b1; if0.dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({if1.dout_valid, if1.dout_last, if1.dout, if1.byte_idx, busy1, done1} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_dut1: got %h expected 0", {if1.dout_valid, if1.dout_last, if1.dout, if1.byte_idx, busy1, done1});
        end
        vectors++;
        if ({if0.dout_valid, if0.dout_last, if0.dout, if0.byte_idx, busy0, done0} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_dut0: got %h expected 0", {if0.dout_valid, if0.dout_last, if0.dout, if0.byte_idx, busy0, done0});
        end
        start1 = 1'b0; start0 = 1'b0; reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if1.dout_valid, busy1, busy0, done1} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 0000", {if1.dout_valid, busy1, busy0, done1});
        end
    endtask

    task automatic test_ramp();
        bit xfer, seen_done;
        logic [13:0] obs, exp;
        int n, j;
        n = 0; j = 0; seen_done = 1'b0;
        params1 = ramp_bank(); start1 = 1'b1;
        push_frame(ramp_bank(), 1'b1);
        while (j < 60 && !seen_done) begin
            step1(1'b1, xfer, obs);
            j++; start1 = 1'b0;
            if (done1) seen_done = 1'b1;
            else if (xfer) begin
                n++;
                vectors++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL ramp_byte: got %h expected %h", obs, exp);
                end
            end
        end
        vectors++;
        if (!seen_done || j != 26 || n != 25) begin
            miscompares++;
            $display("FAIL ramp_timing: got done=%0b cycles=%0d xfers=%0d expected 1 26 25", seen_done, j, n);
        end
        step1(1'b1, xfer, obs);
        vectors++;
        if ({done1, busy1, if1.dout_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL ramp_done_pulse: got %b expected 000", {done1, busy1, if1.dout_valid});
        end
        sb_q.delete();
    endtask

    task automatic test_backpressure();
        bit xfer, seen_done, held;
        logic [13:0] obs, exp, prev;
        int n, j;
        n = 0; j = 0; seen_done = 1'b0; held = 1'b0; prev = 14'd0;
        params1 = ramp_bank(); start1 = 1'b1;
        push_frame(ramp_bank(), 1'b1);
        while (j < 120 && !seen_done) begin
            j++;
            step1(j[0], xfer, obs);
            start1 = 1'b0;
            if (j == 1) params1 = {192{1'b1}};
            if (held) begin
                vectors++;
                if (obs !== prev) begin
                    miscompares++;
                    $display("FAIL bp_stable: got %h expected %h", obs, prev);
                end
            end
            held = if1.dout_valid && !j[0];
            prev = obs;
            if (done1) seen_done = 1'b1;
            else if (xfer) begin
                n++;
                vectors++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL bp_byte: got %h expected %h", obs, exp);
                end
            end
        end
        vectors++;
        if (!seen_done || j != 50 || n != 25) begin
            miscompares++;
            $display("FAIL bp_timing: got done=%0b cycles=%0d xfers=%0d expected 1 50 25", seen_done, j, n);
        end
        sb_q.delete();
    endtask

    task automatic test_no_csum();
        bit xfer, seen_done;
        logic [13:0] obs, exp;
        int n, j;
        n = 0; j = 0; seen_done = 1'b0;
        params0 = {24{8'hA5}}; start0 = 1'b1;
        push_frame({24{8'hA5}}, 1'b0);
        while (j < 60 && !seen_done) begin
            step0(1'b1, xfer, obs);
            j++; start0 = 1'b0;
            if (done0) seen_done = 1'b1;
            else if (xfer) begin
                n++;
                vectors++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL nocsum_byte: got %h expected %h", obs, exp);
                end
            end
        end
        vectors++;
        if (!seen_done || j != 25 || n != 24 || if0.dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nocsum_timing: got done=%0b cycles=%0d xfers=%0d expected 1 25 24", seen_done, j, n);
        end
        sb_q.delete();
    endtask

    task automatic test_abort();
        bit xfer;
        logic [13:0] obs;
        int j;
        j = 0;
        params1 = ramp_bank(); start1 = 1'b1;
        do begin
            step1(1'b1, xfer, obs);
            j++; start1 = 1'b0;
        end while (j < 40 && !(if1.dout_valid && if1.byte_idx == 5'd10));
        reset = 1'b1;
        step1(1'b1, xfer, obs);
        reset = 1'b0;
        vectors++;
        if ({if1.dout_valid, if1.dout_last, if1.dout, if1.byte_idx, busy1, done1} !== 17'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h expected 0 (reached idx10=%0d)", {if1.dout_valid, if1.dout_last, if1.dout, if1.byte_idx, busy1, done1}, j);
        end
        step1(1'b1, xfer, obs);
        vectors++;
        if ({done1, if1.dout_valid, busy1} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_no_done: got %b expected 000", {done1, if1.dout_valid, busy1});
        end
        start1 = 1'b1;
        step1(1'b0, xfer, obs);
        start1 = 1'b0;
        vectors++;
        if ({if1.dout_valid, obs} !== {1'b1, 5'd0, 1'b0, 8'h01}) begin
            miscompares++;
            $display("FAIL abort_restart: got %h expected %h", {if1.dout_valid, obs}, {1'b1, 5'd0, 1'b0, 8'h01});
        end
        reset = 1'b1;
        step1(1'b1, xfer, obs);
        reset = 1'b0;
    endtask

    task automatic test_start_held();
        bit xfer, seen_done;
        logic [13:0] obs, exp;
        int n, j;
        n = 0; j = 0; seen_done = 1'b0;
        params1 = ramp_bank(); start1 = 1'b1;
        push_frame(ramp_bank(), 1'b1);
        while (j < 60 && !seen_done) begin
            step1(1'b1, xfer, obs);
            j++;
            if (done1) seen_done = 1'b1;
            else if (xfer) begin
                n++;
                vectors++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL held_byte: got %h expected %h", obs, exp);
                end
            end
        end
        vectors++;
        if (!seen_done || j != 26 || n != 25 || {if1.dout_valid, busy1} !== 2'b00) begin
            miscompares++;
            $display("FAIL held_gap: got done=%0b cycles=%0d xfers=%0d valid/busy=%b expected 1 26 25 00", seen_done, j, n, {if1.dout_valid, busy1});
        end
        step1(1'b0, xfer, obs);
        start1 = 1'b0;
        vectors++;
        if ({if1.dout_valid, busy1, obs} !== {2'b11, 5'd0, 1'b0, 8'h01}) begin
            miscompares++;
            $display("FAIL held_restart: got %h expected %h", {if1.dout_valid, busy1, obs}, {2'b11, 5'd0, 1'b0, 8'h01});
        end
        sb_q.delete();
        reset = 1'b1;
        step1(1'b1, xfer, obs);
        reset = 1'b0;
    endtask

    task automatic test_loopback();
        bit xfer, seen_done;
        logic [13:0] obs, exp;
        logic [191:0] bank, loader;
        int n, j;
        n = 0; j = 0; seen_done = 1'b0; loader = 192'd0;
        for (int k = 0; k < 6; k++) bank[32*k +: 32] = $urandom;
        params1 = bank; start1 = 1'b1;
        push_frame(bank, 1'b1);
        while (j < 300 && !seen_done) begin
            step1(1'($urandom_range(0, 1)), xfer, obs);
            j++; start1 = 1'b0;
            if (done1) seen_done = 1'b1;
            else if (xfer) begin
                n++;
                if (obs[13:9] < 5'd24) loader = {obs[7:0], loader[191:8]};
                vectors++;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL loop_byte: got %h expected %h", obs, exp);
                end
            end
        end
        vectors++;
        if (!seen_done || n != 25 || loader !== bank) begin
            miscompares++;
            $display("FAIL loop_bank: got %h expected %h (done=%0b xfers=%0d)", loader, bank, seen_done, n);
        end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_ramp();
        @(negedge clk);
        test_backpressure();
        @(negedge clk);
        test_no_csum();
        test_abort();
        test_start_held();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
